// File: rtl/rr_xbar_pkg.sv
// Shared state and command encodings for the 2x2 round-robin crossbar request path.
// Used by rr_master_req_ctrl and rr_ack_arbiter.
package rr_xbar_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } req_state_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/rr_master_req_ctrl_if.sv
// Master-side transaction bus of rr_master_req_ctrl.
// The master modport is the requesting master; the slave modport is the request controller.
interface rr_master_req_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_cmd;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic              m_resp;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  modport master (
    output m_req,
    output m_addr,
    output m_cmd,
    output m_wdata,
    input  m_ack,
    input  m_resp,
    input  m_rdata,
    input  m_err
  );

  modport slave (
    input  m_req,
    input  m_addr,
    input  m_cmd,
    input  m_wdata,
    output m_ack,
    output m_resp,
    output m_rdata,
    output m_err
  );

endinterface

// File: rtl/rr_req_timeout_cnt.sv
// Cycle counter for the W_ACK/W_DATA timeout; expired is high in the LIMIT-th enabled cycle
// after a clear.
module rr_req_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/rr_master_req_ctrl.sv
// Per-master request tracker: latches one transaction and walks NO_REQ/WAIT/W_ACK/W_DATA.
// Optional timeout abort in W_ACK/W_DATA is enabled by defining RR_REQ_TIMEOUT_EN.
import rr_xbar_pkg::*;

module rr_master_req_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_master_req_ctrl_if.slave  mst,
  input  logic [1:0]           s_busy,
  output logic                 s_req,
  output logic [ADDR_W-1:0]    s_addr,
  output logic                 s_cmd,
  output logic [DATA_W-1:0]    s_wdata,
  input  logic                 ack_in,
  input  logic                 s_resp,
  input  logic [DATA_W-1:0]    s_rdata,
  output logic [1:0]           req_stat,
  output logic                 sfor
);

  if (TO_CYCLES < 1) begin : g_to_check
    $error("TO_CYCLES must be at least 1");
  end

  req_state_e        state_q;
  logic              s_req_q;
  logic              sfor_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cmd_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef RR_REQ_TIMEOUT_EN
  logic m_err_q;
  logic to_clr;
  logic to_en;
  logic to_expired;

  // Restart the count on every entry into W_ACK or W_DATA.
  assign to_clr = ((state_q == WAIT) && !s_busy[sfor_q]) ||
                  ((state_q == W_ACK) && ack_in && (cmd_q == CMD_RD));
  assign to_en  = (state_q == W_ACK) || (state_q == W_DATA);

  rr_req_timeout_cnt #(
    .LIMIT (TO_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clr),
    .enable  (to_en),
    .expired (to_expired)
  );

  assign mst.m_err = m_err_q;
`else
  assign mst.m_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NO_REQ;
      s_req_q <= 1'b0;
      sfor_q  <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= CMD_RD;
      wdata_q <= '0;
`ifdef RR_REQ_TIMEOUT_EN
      m_err_q <= 1'b0;
`endif
    end else begin
`ifdef RR_REQ_TIMEOUT_EN
      m_err_q <= 1'b0;
`endif
      unique case (state_q)
        NO_REQ: begin
          if (mst.m_req) begin
            addr_q  <= mst.m_addr;
            cmd_q   <= mst.m_cmd;
            wdata_q <= mst.m_wdata;
            sfor_q  <= mst.m_addr[ADDR_W-1];
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!s_busy[sfor_q]) begin
            s_req_q <= 1'b1;
            state_q <= W_ACK;
          end
        end
        W_ACK: begin
          // An ack in the limit cycle takes priority over the timeout.
          if (ack_in) begin
            s_req_q <= 1'b0;
            state_q <= (cmd_q == CMD_WR) ? NO_REQ : W_DATA;
          end
`ifdef RR_REQ_TIMEOUT_EN
          else if (to_expired) begin
            s_req_q <= 1'b0;
            m_err_q <= 1'b1;
            state_q <= NO_REQ;
          end
`endif
        end
        W_DATA: begin
          if (s_resp) begin
            state_q <= NO_REQ;
          end
`ifdef RR_REQ_TIMEOUT_EN
          else if (to_expired) begin
            m_err_q <= 1'b1;
            state_q <= NO_REQ;
          end
`endif
        end
      endcase
    end
  end

  assign mst.m_ack   = ack_in && (state_q == W_ACK);
  assign mst.m_resp  = s_resp && (state_q == W_DATA);
  assign mst.m_rdata = s_rdata;

  assign s_req    = s_req_q;
  assign s_addr   = addr_q;
  assign s_cmd    = cmd_q;
  assign s_wdata  = wdata_q;
  assign req_stat = state_q;
  assign sfor     = sfor_q;

endmodule

// File: tb/tb_rr_master_req_ctrl.sv
// Self-checking bench for rr_master_req_ctrl; expected behaviour is derived per transaction
// from the WAIT/W_ACK/W_DATA cycle counts implied by busy, ack and response delays.
module tb_rr_master_req_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    s_busy;
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_cmd;
  logic [DW-1:0] s_wdata;
  logic          ack_in;
  logic          s_resp;
  logic [DW-1:0] s_rdata;
  logic [1:0]    req_stat;
  logic          sfor;

  int n_cmp = 0;
  int n_err = 0;

  rr_master_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  rr_master_req_ctrl #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TO_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mst      (mif),
    .s_busy   (s_busy),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_cmd    (s_cmd),
    .s_wdata  (s_wdata),
    .ack_in   (ack_in),
    .s_resp   (s_resp),
    .s_rdata  (s_rdata),
    .req_stat (req_stat),
    .sfor     (sfor)
  );

  always #5 clk = ~clk;

  // One transaction: b busy cycles in WAIT, ack in the (a+1)th W_ACK cycle, response in the
  // (r+1)th W_DATA cycle. Cycle k=0 is the NO_REQ cycle where the request is presented.
  task automatic do_txn(input string name, input logic cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int b, input int a, input int r, input bit noise);
    int   ack_k;
    int   resp_k;
    int   last;
    logic sel;
    ack_k  = b + a + 2;
    resp_k = cmd ? -1 : ack_k + 1 + r;
    last   = cmd ? ack_k : resp_k;
    sel    = addr[AW-1];
    for (int k = 0; k <= last; k++) begin
      logic [1:0] es;
      logic [1:0] bz;
      logic [5:0] exp_v;
      logic [5:0] obs_v;
      es = (k == 0) ? 2'd0 : (k <= b + 1) ? 2'd1 : (k <= ack_k) ? 2'd2 : 2'd3;
      @(posedge clk); #1;
      mif.m_req   = (k <= ack_k) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      mif.m_addr  = (k == 0 || !noise) ? addr : $urandom;
      mif.m_cmd   = (k == 0 || !noise) ? cmd : 1'($urandom);
      mif.m_wdata = (k == 0 || !noise) ? wdata : $urandom;
      bz          = noise ? 2'($urandom) : 2'b00;
      bz[sel]     = (k >= 1 && k <= b);
      s_busy      = bz;
      ack_in      = (k == ack_k) || (noise && es != 2'd2 && ($urandom % 2 == 1));
      s_resp      = (k == resp_k) || (noise && es != 2'd3 && ($urandom % 2 == 1));
      s_rdata     = (k == resp_k) ? rdata : $urandom;
      @(negedge clk);
      exp_v = {es, es == 2'd2, k == ack_k, k == resp_k, 1'b0};
      obs_v = {req_stat, s_req, mif.m_ack, mif.m_resp, mif.m_err};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL %s ctl k=%0d {stat,s_req,ack,resp,err} got %b want %b",
                 name, k, obs_v, exp_v);
      end
      if (k >= 1) begin
        n_cmp++;
        if ({sfor, s_cmd, s_addr, s_wdata} !== {sel, cmd, addr, wdata}) begin
          n_err++;
          $display("FAIL %s latch k=%0d got sfor=%b cmd=%b addr=%h wdata=%h want %b %b %h %h",
                   name, k, sfor, s_cmd, s_addr, s_wdata, sel, cmd, addr, wdata);
        end
      end
      if (k == resp_k) begin
        n_cmp++;
        if (mif.m_rdata !== rdata) begin
          n_err++;
          $display("FAIL %s rdata got %h want %h", name, mif.m_rdata, rdata);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mif.m_req = 1'b0;
      ack_in    = 1'($urandom);
      s_resp    = 1'($urandom);
      s_busy    = 2'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({req_stat, s_req, mif.m_ack, mif.m_resp, mif.m_err} !== 6'b0) begin
        n_err++;
        $display("FAIL idle stat=%0d s_req=%b ack=%b resp=%b err=%b want all 0",
                 req_stat, s_req, mif.m_ack, mif.m_resp, mif.m_err);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      mif.m_req  = 1'b1;
      mif.m_addr = 32'hFFFF_FFFF;
      mif.m_cmd  = 1'b1;
      ack_in     = 1'b1;
      s_resp     = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({req_stat, sfor, s_req, mif.m_ack, mif.m_resp, mif.m_err, s_cmd, s_addr, s_wdata}
          !== '0) begin
        n_err++;
        $display("FAIL reset stat=%0d sfor=%b s_req=%b ack=%b resp=%b err=%b addr=%h wd=%h",
                 req_stat, sfor, s_req, mif.m_ack, mif.m_resp, mif.m_err, s_addr, s_wdata);
      end
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    mif.m_req = 1'b0;
    ack_in    = 1'b0;
    s_resp    = 1'b0;
  endtask

  task automatic test_write();
    do_txn("write", 1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 32'h0, 0, 1, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_read();
    do_txn("read", 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 0, 0, 2, 1'b0);
    idle(1);
  endtask

  task automatic test_busy_stall();
    do_txn("busy_stall", 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 5, 0, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_wr1", 1'b1, 32'h8000_0200, 32'h1357_9BDF, 32'h0, 0, 0, 0, 1'b0);
    do_txn("b2b_rd", 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_0001, 0, 0, 0, 1'b0);
    do_txn("b2b_wr2", 1'b1, 32'h8000_0400, 32'h2468_ACE0, 32'h0, 1, 0, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) begin
      logic [1:0] es;
      es = (k <= 2) ? 2'(k) : (k == 3 || k == 4) ? 2'd3 : 2'd0;
      @(posedge clk); #1;
      mif.m_req   = (k <= 2);
      mif.m_addr  = 32'h8000_0040;
      mif.m_cmd   = 1'b0;
      mif.m_wdata = 32'h7777_7777;
      s_busy      = 2'b00;
      ack_in      = (k == 2);
      rst         = (k == 4);
      s_resp      = (k == 5);
      s_rdata     = 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++;
      if ({req_stat, s_req, mif.m_resp} !== {es, es == 2'd2, 1'b0}) begin
        n_err++;
        $display("FAIL reset_mid k=%0d stat=%0d s_req=%b resp=%b want stat=%0d resp=0",
                 k, req_stat, s_req, mif.m_resp, es);
      end
    end
    n_cmp++;
    if ({sfor, s_cmd, s_addr, s_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mid latch sfor=%b addr=%h wdata=%h want 0", sfor, s_addr, s_wdata);
    end
    @(posedge clk); #1;
    s_resp = 1'b0;
  endtask

`ifdef RR_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int   ack_ks [4] = '{-1, 2, TO + 1, 2};
    int   resp_ks[4] = '{-1, -1, -1, 2 + TO};
    logic cmds   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int sc = 0; sc < 4; sc++) begin
      int wa_end;
      int wd_end;
      int err_k;
      wa_end = (ack_ks[sc] >= 0) ? ack_ks[sc] : TO + 1;
      if (!cmds[sc] && ack_ks[sc] >= 0) wd_end = (resp_ks[sc] >= 0) ? resp_ks[sc] : wa_end + TO;
      else wd_end = wa_end;
      err_k = ((cmds[sc] && ack_ks[sc] >= 0) || resp_ks[sc] >= 0) ? -1 : wd_end + 1;
      for (int k = 0; k < wd_end + 3; k++) begin
        logic [1:0] es;
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        es = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k <= wa_end) ? 2'd2 :
             (k <= wd_end) ? 2'd3 : 2'd0;
        @(posedge clk); #1;
        mif.m_req   = (k <= wa_end);
        mif.m_addr  = 32'(sc * 16);
        mif.m_cmd   = cmds[sc];
        mif.m_wdata = 32'h5000_0000 + 32'(sc);
        s_busy      = 2'b00;
        ack_in      = (k == ack_ks[sc]);
        s_resp      = (k == resp_ks[sc]);
        s_rdata     = 32'hC0DE_0000 + 32'(sc);
        @(negedge clk);
        exp_v = {es, k == ack_ks[sc], k == resp_ks[sc], k == err_k};
        obs_v = {req_stat, mif.m_ack, mif.m_resp, mif.m_err};
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_err++;
          $display("FAIL timeout sc=%0d k=%0d {stat,ack,resp,err} got %b want %b",
                   sc, k, obs_v, exp_v);
        end
      end
    end
  endtask
`else
  task automatic test_timeout();
    do_txn("no_timeout_wr", 1'b1, 32'h8000_0100, 32'h1111_2222, 32'h0, 0, 12, 0, 1'b0);
    do_txn("no_timeout_rd", 1'b0, 32'h0000_0100, 32'h0, 32'h3333_4444, 0, 0, 12, 1'b0);
    idle(1);
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      idle(int'($urandom % 3));
      do_txn("random", 1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), 1'b1);
    end
    idle(1);
  endtask

  initial begin
    rst         = 1'b1;
    mif.m_req   = 1'b0;
    mif.m_addr  = '0;
    mif.m_cmd   = 1'b0;
    mif.m_wdata = '0;
    s_busy      = 2'b00;
    ack_in      = 1'b0;
    s_resp      = 1'b0;
    s_rdata     = '0;
    test_reset();
    test_write();
    test_read();
    test_busy_stall();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
